// File: rtl/mem_access_pkg.sv
// Shared definitions for the RV32 memory-access stage: datapath widths,
// the access FSM state encoding and the alignment helper.
package mem_access_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_ALIGN = 2;
    localparam int REG_ADDR_W = 5;

    localparam int                    INST_SIZE       = XLEN;
    localparam logic [INST_SIZE-1:0]  INST_SIZE_ZEROS = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } memState_e;

    // Only whole-word accesses are legal, so any set low address bit is a fault.
    function automatic logic isMisaligned(input logic [ADDR_ALIGN-1:0] lowBits);
        return lowBits != '0;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus between the memory stage (master)
// and the data memory (slave).
interface mem_access_if;
    import mem_access_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Access sequencer for the memory stage: issues the dmem request, stalls the
// pipe while it is open, buffers load data and flags faulting retirements.
module mem_access_fsm
    import mem_access_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_memWe,
    input  logic            i_memReg,
    mem_access_if.master    bus,
    output logic            o_memStall,
    output logic            o_retireFault,
    output logic            o_memFault,
    output logic [XLEN-1:0] o_rdBuf
);

    memState_e       r_state;
    logic [XLEN-1:0] r_reqAddr;
    logic [XLEN-1:0] r_reqWdata;
    logic            r_reqWe;
    logic [XLEN-1:0] r_rdBuf;
    logic            r_errBuf;
    logic            r_memFault;

    logic w_access;
    logic w_misal;
    logic w_issue;
    logic w_inReq;
    logic w_inResp;
    logic w_reqActive;
    logic w_reqWe;

    assign w_access    = i_memWe | i_memReg;
    assign w_misal     = w_access & isMisaligned(i_addr[ADDR_ALIGN-1:0]);
    assign w_inReq     = (r_state == REQ);
    assign w_inResp    = (r_state == RESP);
    assign w_issue     = (r_state == IDLE) & w_access & ~w_misal;
    assign w_reqActive = i_rst_n & (w_issue | w_inReq);
    assign w_reqWe     = w_inReq ? r_reqWe : i_memWe;

    // While waiting for gnt the request is replayed from the latched copy,
    // so the bus stays stable even if the EX/MEM inputs were to move.
    assign bus.req   = w_reqActive;
    assign bus.we    = w_reqActive & w_reqWe;
    assign bus.addr  = !w_reqActive ? INST_SIZE_ZEROS : (w_inReq ? r_reqAddr : i_addr);
    assign bus.wdata = !w_reqActive ? INST_SIZE_ZEROS : (w_inReq ? r_reqWdata : i_wdata);

    assign o_memStall    = i_rst_n & (w_issue | w_inReq | w_inResp);
    assign o_retireFault = (r_state == DONE) ? r_errBuf : w_misal;
    assign o_memFault    = r_memFault;
    assign o_rdBuf       = r_rdBuf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_reqAddr  <= INST_SIZE_ZEROS;
            r_reqWdata <= INST_SIZE_ZEROS;
            r_reqWe    <= 1'b0;
            r_rdBuf    <= INST_SIZE_ZEROS;
            r_errBuf   <= 1'b0;
            r_memFault <= 1'b0;
        end else begin
            r_memFault <= ~o_memStall & o_retireFault;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_reqAddr  <= i_addr;
                        r_reqWdata <= i_wdata;
                        r_reqWe    <= i_memWe;
                        r_errBuf   <= 1'b0;
                        if (bus.gnt) begin
                            if (i_memWe) begin
                                r_state  <= DONE;
                                r_errBuf <= bus.err;
                            end else begin
                                r_state <= RESP;
                            end
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.gnt) begin
                        if (r_reqWe) begin
                            r_state  <= DONE;
                            r_errBuf <= bus.err;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rvalid) begin
                        r_rdBuf  <= bus.rdata;
                        r_errBuf <= bus.err;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 pipeline: wraps the access sequencer and
// owns the BP_MEM forwarding path and the MEM/WB pipeline register.
module mem_access_stage
    import mem_access_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [XLEN-1:0]       i_aluOut,
    input  logic [XLEN-1:0]       i_wdMe,
    input  logic                  i_memWeMe,
    input  logic                  i_memRegMe,
    input  logic                  i_meWe,
    input  logic [REG_ADDR_W-1:0] i_rd,
    mem_access_if.master          dmem,
    output logic [XLEN-1:0]       o_bpMem,
    output logic                  o_memStall,
    output logic [XLEN-1:0]       o_wbData,
    output logic [REG_ADDR_W-1:0] o_wbRd,
    output logic                  o_wbWe,
    output logic                  o_memFault
);

    logic [XLEN-1:0]       r_wbData;
    logic [REG_ADDR_W-1:0] r_wbRd;
    logic                  r_wbWe;

    logic                  w_memStall;
    logic                  w_retireFault;
    logic [XLEN-1:0]       w_rdBuf;

    mem_access_fsm u_fsm (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_addr        (i_aluOut),
        .i_wdata       (i_wdMe),
        .i_memWe       (i_memWeMe),
        .i_memReg      (i_memRegMe),
        .bus           (dmem),
        .o_memStall    (w_memStall),
        .o_retireFault (w_retireFault),
        .o_memFault    (o_memFault),
        .o_rdBuf       (w_rdBuf)
    );

    assign o_bpMem    = i_aluOut;
    assign o_memStall = w_memStall;
    assign o_wbData   = r_wbData;
    assign o_wbRd     = r_wbRd;
    assign o_wbWe     = r_wbWe;

    // A stalled cycle pushes a bubble into WB but keeps the last data/rd visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbData <= INST_SIZE_ZEROS;
            r_wbRd   <= '0;
            r_wbWe   <= 1'b0;
        end else if (!w_memStall) begin
            r_wbData <= i_memRegMe ? w_rdBuf : i_aluOut;
            r_wbRd   <= i_rd;
            r_wbWe   <= i_meWe & ~w_retireFault;
        end else begin
            r_wbWe   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed scenarios plus randomized
// ALU/load/store entries checked against a transaction-level model.
module tb_mem_access_stage;
    import mem_access_pkg::*;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
        int          stall;
        int          reqs;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        isStore;
    } expItem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aluOut;
    logic [31:0] wdMe;
    logic        memWeMe;
    logic        memRegMe;
    logic        meWe;
    logic [4:0]  rd;
    logic [31:0] bpMem;
    logic        memStall;
    logic [31:0] wbData;
    logic [4:0]  wbRd;
    logic        wbWe;
    logic        memFault;

    mem_access_if dmem();

    mem_access_stage dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_aluOut   (aluOut),
        .i_wdMe     (wdMe),
        .i_memWeMe  (memWeMe),
        .i_memRegMe (memRegMe),
        .i_meWe     (meWe),
        .i_rd       (rd),
        .dmem       (dmem),
        .o_bpMem    (bpMem),
        .o_memStall (memStall),
        .o_wbData   (wbData),
        .o_wbRd     (wbRd),
        .o_wbWe     (wbWe),
        .o_memFault (memFault)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass   = 0;
    expItem_t    sbQ[$];
    expItem_t    curItem;
    logic [31:0] modelBuf;
    int          reqCnt;
    int          stallCnt;
    logic        pending;
    logic        holdValid;
    logic [31:0] lastData;
    logic [4:0]  lastRd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic driveIdle();
        aluOut = '0; wdMe = '0; memWeMe = 1'b0; memRegMe = 1'b0; meWe = 1'b0; rd = '0;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0; dmem.err = 1'b0;
    endtask

    // One pipeline entry: the model computes its retirement, then the memory
    // side is played open-loop with the requested grant/response delays.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rdIn, input logic meWeIn, input int gntDelay,
                                 input int rvDelay, input logic errIn, input logic [31:0] rdataIn,
                                 input logic spurious);
        expItem_t e;
        logic isLoad, isStore, isMem, misal;
        isLoad  = (kind == K_LOAD);
        isStore = (kind == K_STORE);
        isMem   = isLoad || isStore;
        misal   = isMem && (addr[1:0] != 2'b00);
        e.fault   = misal || (isMem && errIn);
        e.data    = isLoad ? (misal ? modelBuf : rdataIn) : addr;
        if (isLoad && !misal) modelBuf = rdataIn;
        e.rd      = rdIn;
        e.we      = meWeIn && !e.fault;
        e.stall   = (!isMem || misal) ? 0 : (isStore ? gntDelay + 1 : gntDelay + rvDelay + 2);
        e.reqs    = (!isMem || misal) ? 0 : gntDelay + 1;
        e.addr    = addr;
        e.wdata   = wdata;
        e.isStore = isStore;
        sbQ.push_back(e);

        aluOut = addr; wdMe = wdata; memWeMe = isStore; memRegMe = isLoad; meWe = meWeIn; rd = rdIn;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.err = 1'b0;
        if (isMem && !misal) begin
            for (int k = 0; k <= gntDelay; k++) begin
                dmem.gnt = (k == gntDelay);
                dmem.err = (isStore && k == gntDelay) ? errIn : 1'b0;
                @(posedge clk); #1;
            end
            dmem.gnt = 1'b0; dmem.err = 1'b0;
            if (isLoad) begin
                for (int k = 0; k <= rvDelay; k++) begin
                    dmem.rvalid = (k == rvDelay);
                    dmem.rdata  = (k == rvDelay) ? rdataIn : $urandom();
                    dmem.err    = (k == rvDelay) ? errIn : 1'b0;
                    @(posedge clk); #1;
                end
                dmem.rvalid = 1'b0; dmem.err = 1'b0;
            end
        end
        if (spurious) begin
            dmem.rvalid = 1'b1;
            dmem.rdata  = $urandom();
            dmem.err    = 1'b1;
        end
        @(posedge clk); #1;
        dmem.rvalid = 1'b0; dmem.err = 1'b0;
    endtask

    // Monitor: counts request/stall cycles per entry, pops at retirement and
    // compares the MEM/WB outputs one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            reqCnt = 0; stallCnt = 0; pending = 1'b0; holdValid = 1'b0;
        end else begin
            if (pending) begin
                checkOutput("wbData", wbData, curItem.data);
                checkOutput("wbRd", 32'(wbRd), 32'(curItem.rd));
                checkOutput("wbWe", 32'(wbWe), 32'(curItem.we));
                checkOutput("memFault", 32'(memFault), 32'(curItem.fault));
                lastData = curItem.data; lastRd = curItem.rd;
                holdValid = 1'b1; pending = 1'b0;
            end else begin
                checkOutput("wbWeBubble", 32'(wbWe), 32'd0);
                checkOutput("memFaultIdle", 32'(memFault), 32'd0);
                if (holdValid) begin
                    checkOutput("wbDataHold", wbData, lastData);
                    checkOutput("wbRdHold", 32'(wbRd), 32'(lastRd));
                end
            end
            checkOutput("bpMem", bpMem, aluOut);
            if (dmem.req) begin
                reqCnt++;
                if (sbQ.size() > 0) begin
                    checkOutput("reqAddr", dmem.addr, sbQ[0].addr);
                    checkOutput("reqWdata", dmem.wdata, sbQ[0].wdata);
                    checkOutput("reqWe", 32'(dmem.we), 32'(sbQ[0].isStore));
                end
            end
            if (memStall) begin
                stallCnt++;
            end else if (sbQ.size() > 0) begin
                curItem = sbQ.pop_front();
                checkOutput("reqCycles", reqCnt, curItem.reqs);
                checkOutput("stallCycles", stallCnt, curItem.stall);
                reqCnt = 0; stallCnt = 0; pending = 1'b1;
            end else begin
                reqCnt = 0; stallCnt = 0; holdValid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        logic [31:0] addr;
        int          kind;
        rst_n = 1'b0;
        modelBuf = '0;
        driveIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReq", 32'(dmem.req), 32'd0);
        checkOutput("rstStall", 32'(memStall), 32'd0);
        checkOutput("rstWbData", wbData, 32'd0);
        checkOutput("rstWbRd", 32'(wbRd), 32'd0);
        checkOutput("rstWbWe", 32'(wbWe), 32'd0);
        checkOutput("rstFault", 32'(memFault), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(K_ALU,   32'h55,  32'h0,    5'd7,  1'b1, 0, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(K_LOAD,  32'h100, 32'h0,    5'd3,  1'b1, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        applyStimulus(K_STORE, 32'h40,  32'h1234, 5'd0,  1'b0, 3, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(K_LOAD,  32'h102, 32'h0,    5'd4,  1'b1, 0, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(K_LOAD,  32'h200, 32'h0,    5'd5,  1'b1, 1, 2, 1'b1, 32'hCAFEF00D, 1'b0);
        applyStimulus(K_STORE, 32'h44,  32'h77,   5'd6,  1'b1, 0, 0, 1'b1, 32'h0, 1'b1);
        applyStimulus(K_ALU,   32'hA5A5, 32'h0,   5'd8,  1'b1, 0, 0, 1'b0, 32'h0, 1'b1);

        // Reset while the load is waiting for its response.
        aluOut = 32'h300; wdMe = '0; memWeMe = 1'b0; memRegMe = 1'b1; meWe = 1'b1; rd = 5'd9;
        dmem.gnt = 1'b1;
        @(posedge clk); #1;
        dmem.gnt = 1'b0;
        checkOutput("stallInResp", 32'(memStall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstReq", 32'(dmem.req), 32'd0);
        checkOutput("midRstWe", 32'(dmem.we), 32'd0);
        checkOutput("midRstAddr", dmem.addr, 32'd0);
        checkOutput("midRstStall", 32'(memStall), 32'd0);
        checkOutput("midRstWbData", wbData, 32'd0);
        checkOutput("midRstWbRd", 32'(wbRd), 32'd0);
        checkOutput("midRstWbWe", 32'(wbWe), 32'd0);
        checkOutput("midRstFault", 32'(memFault), 32'd0);
        sbQ.delete();
        modelBuf = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(K_ALU, 32'h1111, 32'h0, 5'd10, 1'b1, 0, 0, 1'b0, 32'h0, 1'b1);
        applyStimulus(K_LOAD, 32'h104, 32'h0, 5'd11, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0);
        applyStimulus(K_LOAD, 32'h105, 32'h0, 5'd12, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 2));
            rnd  = $urandom();
            addr = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(kind, addr, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 2) == 0));
        end

        driveIdle();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
